// File: rtl/axi_read_responder_if.sv
// AXI read-channel bundle (AR + R) between a fetch master and axi_read_responder.
interface axi_read_responder_if;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [3:0]  ARID;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [3:0]  RID;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    modport slave (
        input  ARADDR, ARLEN, ARID, ARVALID, RREADY,
        output ARREADY, RDATA, RID, RLAST, RVALID
    );

    modport master (
        output ARADDR, ARLEN, ARID, ARVALID, RREADY,
        input  ARREADY, RDATA, RID, RLAST, RVALID
    );
endinterface

// File: rtl/axi_read_responder.sv
// AXI read responder: queues AR bursts and returns them in order from a word-addressed ROM.
// Optional AXI_RD_LATENCY_EN stretches the pre-burst wait to LATENCY cycles.
module axi_read_responder #(
  parameter int unsigned MEM_WORDS     = 4096,
  parameter int unsigned AR_FIFO_DEPTH = 4,
  parameter int unsigned LATENCY       = 4,
  parameter string       INIT_FILE     = ""
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi_read_responder_if.slave  bus
);
  localparam int unsigned WAW     = $clog2(MEM_WORDS);
  localparam int unsigned PW      = $clog2(AR_FIFO_DEPTH);
  localparam int unsigned LAT_EFF = (LATENCY == 0) ? 1 : LATENCY;
  localparam int unsigned CW      = $clog2(LAT_EFF + 1);
`ifdef AXI_RD_LATENCY_EN
  localparam int unsigned WAIT_CYCLES = LAT_EFF;
`else
  localparam int unsigned WAIT_CYCLES = 1;
`endif
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  logic [31:0] mem [MEM_WORDS];

  initial begin
    for (int unsigned i = 0; i < MEM_WORDS; i++) mem[i] = '0;
  end

  logic [WAW-1:0] q_addr [AR_FIFO_DEPTH];
  logic [7:0]     q_len  [AR_FIFO_DEPTH];
  logic [3:0]     q_id   [AR_FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [PW:0]    count;

  state_t         state;
  logic [WAW-1:0] b_addr;
  logic [7:0]     b_left;
  logic [CW-1:0]  lat_cnt;
  logic           r_valid, r_last;
  logic [3:0]     r_id;
  logic [31:0]    r_data;

  logic           full, empty, push, pop, beat_hs, last_hs;
  logic [WAW-1:0] next_addr;
  logic           unused_addr_bits;

  assign full      = (count == (PW + 1)'(AR_FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push      = bus.ARVALID && !full;
  assign beat_hs   = (state == S_BURST) && r_valid && bus.RREADY;
  assign last_hs   = beat_hs && r_last;
  // The head is popped either from IDLE or in the same cycle the previous burst ends.
  assign pop       = !empty && ((state == S_IDLE) || last_hs);
  assign next_addr = b_addr + 1'b1;

  assign unused_addr_bits = ^{bus.ARADDR[31:WAW+2], bus.ARADDR[1:0]};

  assign bus.ARREADY = !full;
  assign bus.RVALID  = r_valid;
  assign bus.RLAST   = r_last;
  assign bus.RID     = r_id;
  assign bus.RDATA   = r_data;

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= bus.ARADDR[WAW+1:2];
      q_len[wr_ptr]  <= (bus.ARLEN == '0) ? 8'd1 : bus.ARLEN;
      q_id[wr_ptr]   <= bus.ARID;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      state   <= S_IDLE;
      b_addr  <= '0;
      b_left  <= '0;
      lat_cnt <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_id    <= '0;
      r_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count <= count + (PW + 1)'(push) - (PW + 1)'(pop);
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        b_addr  <= q_addr[rd_ptr];
        b_left  <= q_len[rd_ptr];
        r_id    <= q_id[rd_ptr];
        lat_cnt <= WAIT_LOAD;
      end

      case (state)
        S_IDLE: begin
          if (pop) state <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt == '0) begin
            state   <= S_BURST;
            r_valid <= 1'b1;
            r_data  <= mem[b_addr];
            r_last  <= (b_left == 8'd1);
          end else begin
            lat_cnt <= lat_cnt - CW'(1);
          end
        end
        S_BURST: begin
          if (beat_hs) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              state   <= pop ? S_WAIT : S_IDLE;
            end else begin
              b_addr <= next_addr;
              b_left <= b_left - 8'd1;
              r_data <= mem[next_addr];
              r_last <= (b_left == 8'd2);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_read_responder.sv
// Scoreboard bench for axi_read_responder; memory is preloaded so word k holds k.
module tb_axi_read_responder;
    localparam int unsigned MEM_WORDS = 4096;
    localparam int unsigned LATENCY   = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  id;
        logic        last;
    } beat_t;

    logic clk;
    logic rst_n;
    axi_read_responder_if bus ();

    axi_read_responder #(
        .MEM_WORDS(MEM_WORDS),
        .AR_FIFO_DEPTH(4),
        .LATENCY(LATENCY),
        .INIT_FILE("")
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    beat_t exp_q[$];
    beat_t obs_q[$];
    int errors = 0;
    int checks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len,
                           input logic [3:0] id, output bit ok);
        int n;
        beat_t e;
        ok = 1'b0;
        bus.ARADDR = addr; bus.ARLEN = len; bus.ARID = id; bus.ARVALID = 1'b1;
        for (int c = 0; c < 64 && !ok; c++) begin
            if (bus.ARREADY) begin
                ok = 1'b1;
                n = (len == 8'd0) ? 1 : int'(len);
                for (int b = 0; b < n; b++) begin
                    e.data = 32'((int'(addr[31:2]) + b) % MEM_WORDS);
                    e.id   = id;
                    e.last = (b == n - 1);
                    exp_q.push_back(e);
                end
            end
            @(posedge clk); #1;
        end
        bus.ARVALID = 1'b0;
    endtask

    task automatic collect(input int n, input bit toggle, output bit timed_out, output int unstable);
        beat_t cur, prev;
        bit stalled;
        int got, cyc;
        got = 0; cyc = 0; stalled = 1'b0; unstable = 0; timed_out = 1'b0; prev = '0;
        while (got < n) begin
            bus.RREADY = toggle ? (cyc % 2 == 0) : 1'b1;
            cur = {bus.RDATA, bus.RID, bus.RLAST};
            if (stalled && (!bus.RVALID || cur !== prev)) unstable++;
            if (bus.RVALID && bus.RREADY) begin
                obs_q.push_back(cur);
                got++;
            end
            stalled = bus.RVALID && !bus.RREADY;
            prev = cur;
            if (cyc >= n * 4 + 40) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.RREADY = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.RVALID !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", bus.RVALID); end
        checks++; if (bus.RLAST !== 1'b0) begin errors++; $display("FAIL reset_rlast got=%b exp=0", bus.RLAST); end
        checks++; if (bus.RID !== 4'h0) begin errors++; $display("FAIL reset_rid got=%h exp=0", bus.RID); end
        checks++; if (bus.RDATA !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.RDATA); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.ARREADY !== 1'b1) begin errors++; $display("FAIL reset_arready got=%b exp=1", bus.ARREADY); end
    endtask

    task automatic test_basic_burst();
        bit ok, to; int uns; beat_t o, e;
        send_ar(32'h40, 8'd4, 4'd2, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_ar_accept got=%b exp=1", ok); end
        collect(4, 1'b0, to, uns);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got=%b exp=0", to); end
        checks++; if (obs_q.size() !== 4) begin errors++; $display("FAIL basic_count got=%0d exp=4", obs_q.size()); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            checks++;
            if (o !== e) begin errors++; $display("FAIL basic_beat got data=%h id=%h last=%b exp data=%h id=%h last=%b", o.data, o.id, o.last, e.data, e.id, e.last); end
        end
        checks++; if (bus.RVALID !== 1'b0) begin errors++; $display("FAIL basic_idle_rvalid got=%b exp=0", bus.RVALID); end
    endtask

    task automatic test_single_beat();
        bit ok, to; int uns; beat_t o, e;
        send_ar(32'h8, 8'd0, 4'd5, ok);
        collect(1, 1'b0, to, uns);
        checks++; if (ok !== 1'b1 || to !== 1'b0) begin errors++; $display("FAIL single_handshake got ok=%b to=%b exp ok=1 to=0", ok, to); end
        o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        checks++; if (o !== e) begin errors++; $display("FAIL single_beat got data=%h id=%h last=%b exp data=%h id=%h last=%b", o.data, o.id, o.last, e.data, e.id, e.last); end
        checks++; if (o.data !== 32'd2 || o.last !== 1'b1) begin errors++; $display("FAIL single_value got data=%h last=%b exp data=2 last=1", o.data, o.last); end
        @(posedge clk); #1;
        checks++; if (bus.RVALID !== 1'b0) begin errors++; $display("FAIL single_no_extra got=%b exp=0", bus.RVALID); end
    endtask

    task automatic test_wrap();
        bit ok, to; int uns; beat_t o, e;
        logic [31:0] words [4];
        words[0] = 32'd4094; words[1] = 32'd4095; words[2] = 32'd0; words[3] = 32'd1;
        send_ar(32'h3FF8, 8'd4, 4'd7, ok);
        collect(4, 1'b0, to, uns);
        checks++; if (ok !== 1'b1 || to !== 1'b0) begin errors++; $display("FAIL wrap_handshake got ok=%b to=%b exp ok=1 to=0", ok, to); end
        for (int i = 0; i < 4; i++) begin
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            checks++;
            if (o !== e || o.data !== words[i]) begin errors++; $display("FAIL wrap_beat%0d got data=%h id=%h last=%b exp data=%h id=%h last=%b", i, o.data, o.id, o.last, words[i], e.id, e.last); end
        end
    endtask

    task automatic test_stall_toggle();
        bit ok, to; int uns; beat_t o, e;
        send_ar(32'h100, 8'd8, 4'd9, ok);
        collect(8, 1'b1, to, uns);
        checks++; if (ok !== 1'b1 || to !== 1'b0) begin errors++; $display("FAIL stall_handshake got ok=%b to=%b exp ok=1 to=0", ok, to); end
        checks++; if (uns !== 0) begin errors++; $display("FAIL stall_stability got changes=%0d exp=0", uns); end
        checks++; if (obs_q.size() !== 8) begin errors++; $display("FAIL stall_count got=%0d exp=8", obs_q.size()); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            checks++;
            if (o !== e) begin errors++; $display("FAIL stall_beat got data=%h id=%h last=%b exp data=%h id=%h last=%b", o.data, o.id, o.last, e.data, e.id, e.last); end
        end
        @(posedge clk); #1;
        checks++; if (bus.RVALID !== 1'b0) begin errors++; $display("FAIL stall_no_dup got=%b exp=0", bus.RVALID); end
    endtask

    task automatic test_fifo_full();
        bit ok; int seen_ready, acc_at, cyc; bit accepted; beat_t o, e;
        bus.RREADY = 1'b0;
        // One request moves straight into the burst registers, so four more fill the queue.
        for (int i = 1; i <= 5; i++) begin
            send_ar(32'h400 + 32'(i * 16), 8'd2, 4'(i), ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL full_accept%0d got=%b exp=1", i, ok); end
        end
        bus.ARADDR = 32'h500; bus.ARLEN = 8'd2; bus.ARID = 4'd6; bus.ARVALID = 1'b1;
        seen_ready = 0;
        repeat (8) begin
            if (bus.ARREADY) seen_ready++;
            @(posedge clk); #1;
        end
        checks++; if (seen_ready !== 0) begin errors++; $display("FAIL full_arready_low got ready_cycles=%0d exp=0", seen_ready); end
        accepted = 1'b0; acc_at = -1; cyc = 0;
        bus.RREADY = 1'b1;
        while ((obs_q.size() < 12 || !accepted) && cyc < 120) begin
            if (bus.ARVALID && bus.ARREADY) begin
                accepted = 1'b1;
                acc_at = obs_q.size();
                for (int b = 0; b < 2; b++) begin
                    e.data = 32'(('h500 >> 2) + b); e.id = 4'd6; e.last = (b == 1);
                    exp_q.push_back(e);
                end
            end
            if (bus.RVALID && bus.RREADY) obs_q.push_back({bus.RDATA, bus.RID, bus.RLAST});
            @(posedge clk); #1;
            if (accepted) bus.ARVALID = 1'b0;
            cyc++;
        end
        bus.RREADY = 1'b0;
        bus.ARVALID = 1'b0;
        checks++; if (acc_at !== 2) begin errors++; $display("FAIL full_sixth_accept got beats_before=%0d exp=2", acc_at); end
        checks++; if (obs_q.size() !== 12) begin errors++; $display("FAIL full_count got=%0d exp=12", obs_q.size()); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            checks++;
            if (o !== e) begin errors++; $display("FAIL full_order got data=%h id=%h last=%b exp data=%h id=%h last=%b", o.data, o.id, o.last, e.data, e.id, e.last); end
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok, to; int uns, late; beat_t o, e;
        bus.RREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_ar(32'h600 + 32'(i * 32), 8'd4, 4'(10 + i), ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_accept%0d got=%b exp=1", i, ok); end
        end
        collect(1, 1'b0, to, uns);
        o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        checks++; if (to !== 1'b0 || o !== e) begin errors++; $display("FAIL rstmid_beat1 got data=%h id=%h to=%b exp data=%h id=%h to=0", o.data, o.id, to, e.data, e.id); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.RVALID !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid got=%b exp=0", bus.RVALID); end
        rst_n = 1'b1;
        exp_q.delete();
        obs_q.delete();
        late = 0;
        bus.RREADY = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.RVALID) late++;
        end
        bus.RREADY = 1'b0;
        checks++; if (late !== 0) begin errors++; $display("FAIL rstmid_no_beats got rvalid_cycles=%0d exp=0", late); end
        checks++; if (bus.ARREADY !== 1'b1) begin errors++; $display("FAIL rstmid_arready got=%b exp=1", bus.ARREADY); end
    endtask

    task automatic test_after_reset();
        bit ok, to; int uns, lat, lat_exp; beat_t o, e;
`ifdef AXI_RD_LATENCY_EN
        lat_exp = ((LATENCY == 0) ? 1 : LATENCY) + 1;
`else
        lat_exp = 2;
`endif
        send_ar(32'h200, 8'd3, 4'hC, ok);
        lat = 0;
        while (!bus.RVALID && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (ok !== 1'b1 || lat !== lat_exp) begin errors++; $display("FAIL post_latency got ok=%b cycles=%0d exp ok=1 cycles=%0d", ok, lat, lat_exp); end
        collect(3, 1'b0, to, uns);
        checks++; if (to !== 1'b0 || obs_q.size() !== 3) begin errors++; $display("FAIL post_count got=%0d to=%b exp=3 to=0", obs_q.size(), to); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            checks++;
            if (o !== e) begin errors++; $display("FAIL post_beat got data=%h id=%h last=%b exp data=%h id=%h last=%b", o.data, o.id, o.last, e.data, e.id, e.last); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.ARADDR = '0; bus.ARLEN = '0; bus.ARID = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
        #2;
        for (int k = 0; k < int'(MEM_WORDS); k++) dut.mem[k] = 32'(k);
        test_reset();
        test_basic_burst();
        test_single_beat();
        test_wrap();
        test_stall_toggle();
        test_fifo_full();
        test_reset_mid_burst();
        test_after_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
